// File: rtl/tight_acc_mem_sched.sv
// Memory request scheduler: round-robin arbitration of lanes onto one request slot, transid pool and response routing.
// Optional build macro TIGHT_ACC_MEM_SCHED_PRIO_EN gives lane 0 fixed priority over the round-robin lanes.
module tight_acc_mem_sched #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 40,
  parameter int RESP_W          = 512,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_val,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [5:0]                mem_req_transid,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_resp_val,
  input  logic [5:0]                mem_resp_transid,
  input  logic [RESP_W-1:0]         mem_resp_data,
  output logic [NUM_REQ-1:0]        rsp_val,
  output logic [RESP_W-1:0]         rsp_data,
  output logic [CNT_W-1:0]          outstanding_cnt,
  output logic                      err_unexp
);

  localparam int LANE_W = $clog2(NUM_REQ);
  localparam int TIDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {EMPTY, PENDING} slot_state_t;

  slot_state_t       state_reg, state_next;
  logic [LANE_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic              tag_valid_reg [MAX_OUTSTANDING];
  logic [LANE_W-1:0] tag_owner_reg [MAX_OUTSTANDING];

  logic              arb_found;
  logic [LANE_W-1:0] winner;
  logic              free_any;
  logic [TIDX_W-1:0] free_idx;
  logic              grant;
  logic              resp_in_range;
  logic [TIDX_W-1:0] resp_idx;
  logic              resp_hit;
  logic              resp_unexp;

  // Lowest-index free tag; a tag freed this cycle still looks valid here.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!tag_valid_reg[i]) begin
        free_any = 1'b1;
        free_idx = TIDX_W'(i);
      end
    end
  end

  // rr_ptr_reg holds the highest-priority lane, i.e. last winner + 1.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    winner    = '0;
    idx       = 0;
`ifdef TIGHT_ACC_MEM_SCHED_PRIO_EN
    if (req_val[0]) begin
      arb_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
        if (!arb_found && idx != 0 && req_val[idx]) begin
          arb_found = 1'b1;
          winner    = LANE_W'(idx);
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (!arb_found && req_val[idx]) begin
        arb_found = 1'b1;
        winner    = LANE_W'(idx);
      end
    end
`endif
  end

  assign grant   = arb_found && free_any && (state_reg == EMPTY || mem_req_rdy);
  assign req_rdy = grant ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    // Lane 0 never wins through the pointer in priority mode, so excluding it is enough.
`ifdef TIGHT_ACC_MEM_SCHED_PRIO_EN
    if (grant && winner != '0)
`else
    if (grant)
`endif
      rr_ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (grant) state_next = PENDING;
      PENDING: if (grant) state_next = PENDING;
               else if (mem_req_rdy) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign mem_req_val = (state_reg == PENDING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= EMPTY;
      rr_ptr_reg      <= '0;
      mem_req_transid <= '0;
      mem_req_addr    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (grant) begin
        mem_req_transid <= 6'(free_idx);
        mem_req_addr    <= req_addr[winner*ADDR_W +: ADDR_W];
      end
    end
  end

  assign resp_in_range = 32'(mem_resp_transid) < 32'(MAX_OUTSTANDING);
  assign resp_idx      = mem_resp_transid[TIDX_W-1:0];
  assign resp_hit      = mem_resp_val && resp_in_range && tag_valid_reg[resp_idx];
  assign resp_unexp    = mem_resp_val && !resp_hit;

  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          tag_valid_reg[gi] <= 1'b0;
        else if (grant && free_idx == TIDX_W'(gi))
          tag_valid_reg[gi] <= 1'b1;
        else if (resp_hit && resp_idx == TIDX_W'(gi))
          tag_valid_reg[gi] <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (grant && free_idx == TIDX_W'(gi))
          tag_owner_reg[gi] <= winner;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_val         <= '0;
      rsp_data        <= '0;
      outstanding_cnt <= '0;
      err_unexp       <= 1'b0;
    end else begin
      rsp_val <= resp_hit ? (NUM_REQ'(1) << tag_owner_reg[resp_idx]) : '0;
      if (resp_hit)
        rsp_data <= mem_resp_data;
      if (grant && !resp_hit)
        outstanding_cnt <= outstanding_cnt + 1'b1;
      else if (!grant && resp_hit)
        outstanding_cnt <= outstanding_cnt - 1'b1;
      if (resp_unexp)
        err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tight_acc_mem_sched.sv
// Directed self-checking bench for tight_acc_mem_sched (NUM_REQ=4, MAX_OUTSTANDING=8).
// Define TIGHT_ACC_MEM_SCHED_PRIO_EN to swap the fairness scenario for the lane-0 priority scenario.
module tb_tight_acc_mem_sched;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 40;
  localparam int RESP_W  = 512;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req_val = '0;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic                      mem_req_val;
  logic                      mem_req_rdy = 1'b0;
  logic [5:0]                mem_req_transid;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic                      mem_resp_val = 1'b0;
  logic [5:0]                mem_resp_transid = '0;
  logic [RESP_W-1:0]         mem_resp_data = '0;
  logic [NUM_REQ-1:0]        rsp_val;
  logic [RESP_W-1:0]         rsp_data;
  logic [3:0]                outstanding_cnt;
  logic                      err_unexp;

  int checks = 0;
  int passes = 0;

  tight_acc_mem_sched #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(8), .ADDR_W(ADDR_W), .RESP_W(RESP_W)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid), .mem_resp_data(mem_resp_data),
    .rsp_val(rsp_val), .rsp_data(rsp_data),
    .outstanding_cnt(outstanding_cnt), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int lane, input logic [ADDR_W-1:0] a);
    req_addr[lane*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic do_reset();
    req_val = '0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req_val !== 1'b0) $display("FAIL reset_mem_req_val: got %b want 0", mem_req_val); else passes++;
    checks++; if (mem_req_transid !== 6'd0) $display("FAIL reset_transid: got %0d want 0", mem_req_transid); else passes++;
    checks++; if (mem_req_addr !== 40'd0) $display("FAIL reset_addr: got %h want 0", mem_req_addr); else passes++;
    checks++; if (rsp_val !== 4'b0000) $display("FAIL reset_rsp_val: got %b want 0000", rsp_val); else passes++;
    checks++; if (rsp_data !== 512'd0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data[63:0]); else passes++;
    checks++; if (outstanding_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", outstanding_cnt); else passes++;
    checks++; if (err_unexp !== 1'b0) $display("FAIL reset_err: got %b want 0", err_unexp); else passes++;
    checks++; if (req_rdy !== 4'b0000) $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); else passes++;
    tick();
    rst = 1'b0;
    #1;
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    do_reset();
    set_addr(0, 40'h1000);
    req_val = 4'b0001; mem_req_rdy = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b0001) $display("FAIL single_req_rdy: got %b want 0001", req_rdy); else passes++;
    tick();
    req_val = '0;
    checks++; if (mem_req_val !== 1'b1) $display("FAIL single_mem_req_val: got %b want 1", mem_req_val); else passes++;
    checks++; if (mem_req_transid !== 6'd0) $display("FAIL single_transid: got %0d want 0", mem_req_transid); else passes++;
    checks++; if (mem_req_addr !== 40'h1000) $display("FAIL single_addr: got %h want 1000", mem_req_addr); else passes++;
    checks++; if (outstanding_cnt !== 4'd1) $display("FAIL single_cnt_alloc: got %0d want 1", outstanding_cnt); else passes++;
    tick();
    checks++; if (mem_req_val !== 1'b0) $display("FAIL single_drain: got %b want 0", mem_req_val); else passes++;
    mem_resp_val = 1'b1; mem_resp_transid = 6'd0; mem_resp_data = 512'hAB;
    tick();
    mem_resp_val = 1'b0;
    checks++; if (rsp_val !== 4'b0001) $display("FAIL single_rsp_val: got %b want 0001", rsp_val); else passes++;
    checks++; if (rsp_data !== 512'hAB) $display("FAIL single_rsp_data: got %h want ab", rsp_data[63:0]); else passes++;
    checks++; if (outstanding_cnt !== 4'd0) $display("FAIL single_cnt_free: got %0d want 0", outstanding_cnt); else passes++;
    tick();
    checks++; if (rsp_val !== 4'b0000) $display("FAIL single_rsp_pulse: got %b want 0000", rsp_val); else passes++;
    $display("single: tag 0 issued and returned to lane 0");
  endtask

`ifndef TIGHT_ACC_MEM_SCHED_PRIO_EN
  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_addr(i, 40'(32'h100 * (i + 1)));
    req_val = 4'b1111; mem_req_rdy = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      checks++; if (req_rdy !== exp_rdy) $display("FAIL fair_req_rdy[%0d]: got %b want %b", k, req_rdy, exp_rdy); else passes++;
      tick();
      checks++; if (mem_req_val !== 1'b1) $display("FAIL fair_val[%0d]: got %b want 1", k, mem_req_val); else passes++;
      checks++; if (mem_req_transid !== 6'(k)) $display("FAIL fair_transid[%0d]: got %0d want %0d", k, mem_req_transid, k); else passes++;
      checks++; if (mem_req_addr !== 40'(32'h100 * ((k % 4) + 1))) $display("FAIL fair_addr[%0d]: got %h want %h", k, mem_req_addr, 32'h100 * ((k % 4) + 1)); else passes++;
      $display("fairness: grant %0d lane %0d transid %0d", k, k % 4, mem_req_transid);
    end
    checks++; if (req_rdy !== 4'b0000) $display("FAIL fair_full_rdy: got %b want 0000", req_rdy); else passes++;
    checks++; if (outstanding_cnt !== 4'd8) $display("FAIL fair_full_cnt: got %0d want 8", outstanding_cnt); else passes++;
    req_val = '0;
    tick();
    checks++; if (mem_req_val !== 1'b0) $display("FAIL fair_drain: got %b want 0", mem_req_val); else passes++;
  endtask
`else
  task automatic test_prio();
    logic [NUM_REQ-1:0] exp_rdy;
    do_reset();
    req_val = 4'b1111; mem_req_rdy = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (req_rdy !== 4'b0001) $display("FAIL prio_lane0[%0d]: got %b want 0001", k, req_rdy); else passes++;
      tick();
      $display("prio: grant %0d to lane 0", k);
    end
    req_val = 4'b1110;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_rdy = 4'b0010 << k;
      checks++; if (req_rdy !== exp_rdy) $display("FAIL prio_rr[%0d]: got %b want %b", k, req_rdy, exp_rdy); else passes++;
      tick();
      checks++; if (mem_req_transid !== 6'(4 + k)) $display("FAIL prio_transid[%0d]: got %0d want %0d", k, mem_req_transid, 4 + k); else passes++;
      $display("prio: grant to lane %0d", k + 1);
    end
    req_val = '0;
    tick();
  endtask
`endif

  task automatic test_backpressure();
    do_reset();
    set_addr(0, 40'h2000); set_addr(1, 40'h3000);
    req_val = 4'b0011; mem_req_rdy = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0001) $display("FAIL bp_first_grant: got %b want 0001", req_rdy); else passes++;
    tick();
    req_val = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_req_val !== 1'b1) $display("FAIL bp_val[%0d]: got %b want 1", i, mem_req_val); else passes++;
      checks++; if (mem_req_transid !== 6'd0) $display("FAIL bp_transid[%0d]: got %0d want 0", i, mem_req_transid); else passes++;
      checks++; if (mem_req_addr !== 40'h2000) $display("FAIL bp_addr[%0d]: got %h want 2000", i, mem_req_addr); else passes++;
      checks++; if (req_rdy !== 4'b0000) $display("FAIL bp_no_grant[%0d]: got %b want 0000", i, req_rdy); else passes++;
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    checks++; if (req_rdy !== 4'b0010) $display("FAIL bp_drain_grant: got %b want 0010", req_rdy); else passes++;
    tick();
    req_val = '0;
    checks++; if (mem_req_val !== 1'b1) $display("FAIL bp_b2b_val: got %b want 1", mem_req_val); else passes++;
    checks++; if (mem_req_transid !== 6'd1) $display("FAIL bp_b2b_transid: got %0d want 1", mem_req_transid); else passes++;
    checks++; if (mem_req_addr !== 40'h3000) $display("FAIL bp_b2b_addr: got %h want 3000", mem_req_addr); else passes++;
    tick();
    checks++; if (mem_req_val !== 1'b0) $display("FAIL bp_empty: got %b want 0", mem_req_val); else passes++;
    checks++; if (outstanding_cnt !== 4'd2) $display("FAIL bp_cnt: got %0d want 2", outstanding_cnt); else passes++;
    $display("backpressure: slot held 5 cycles, back-to-back grant on drain");
  endtask

  task automatic test_out_of_order();
    do_reset();
    mem_req_rdy = 1'b1;
    req_val = 4'b1110; tick();
    req_val = 4'b1100; tick();
    req_val = 4'b1000; tick();
    req_val = 4'b0000; tick();
    checks++; if (outstanding_cnt !== 4'd3) $display("FAIL ooo_cnt: got %0d want 3", outstanding_cnt); else passes++;
    mem_resp_val = 1'b1; mem_resp_transid = 6'd2; mem_resp_data = 512'h22;
    tick();
    checks++; if (rsp_val !== 4'b1000) $display("FAIL ooo_rsp_tag2: got %b want 1000", rsp_val); else passes++;
    checks++; if (rsp_data !== 512'h22) $display("FAIL ooo_data_tag2: got %h want 22", rsp_data[63:0]); else passes++;
    mem_resp_transid = 6'd0; mem_resp_data = 512'h11;
    tick();
    checks++; if (rsp_val !== 4'b0010) $display("FAIL ooo_rsp_tag0: got %b want 0010", rsp_val); else passes++;
    checks++; if (rsp_data !== 512'h11) $display("FAIL ooo_data_tag0: got %h want 11", rsp_data[63:0]); else passes++;
    mem_resp_transid = 6'd1; mem_resp_data = 512'h33;
    tick();
    mem_resp_val = 1'b0;
    checks++; if (rsp_val !== 4'b0100) $display("FAIL ooo_rsp_tag1: got %b want 0100", rsp_val); else passes++;
    tick();
    checks++; if (rsp_val !== 4'b0000) $display("FAIL ooo_rsp_idle: got %b want 0000", rsp_val); else passes++;
    checks++; if (outstanding_cnt !== 4'd0) $display("FAIL ooo_cnt_end: got %0d want 0", outstanding_cnt); else passes++;
    $display("out_of_order: responses 2,0,1 routed to lanes 3,1,2");
  endtask

  task automatic test_pool_full();
    do_reset();
    mem_req_rdy = 1'b1;
    req_val = 4'b1110;
    for (int k = 0; k < 8; k++) tick();
    req_val = '0;
    tick();
    checks++; if (outstanding_cnt !== 4'd8) $display("FAIL full_cnt: got %0d want 8", outstanding_cnt); else passes++;
    set_addr(0, 40'h4000);
    req_val = 4'b0001;
    mem_resp_val = 1'b1; mem_resp_transid = 6'd3; mem_resp_data = 512'h77;
    #1;
    checks++; if (req_rdy !== 4'b0000) $display("FAIL full_no_grant: got %b want 0000", req_rdy); else passes++;
    tick();
    mem_resp_val = 1'b0;
    checks++; if (rsp_val !== 4'b0010) $display("FAIL full_rsp_tag3: got %b want 0010", rsp_val); else passes++;
    checks++; if (outstanding_cnt !== 4'd7) $display("FAIL full_cnt_free: got %0d want 7", outstanding_cnt); else passes++;
    #1;
    checks++; if (req_rdy !== 4'b0001) $display("FAIL full_grant_next: got %b want 0001", req_rdy); else passes++;
    tick();
    req_val = '0;
    checks++; if (mem_req_transid !== 6'd3) $display("FAIL full_realloc_tag: got %0d want 3", mem_req_transid); else passes++;
    checks++; if (mem_req_addr !== 40'h4000) $display("FAIL full_realloc_addr: got %h want 4000", mem_req_addr); else passes++;
    checks++; if (outstanding_cnt !== 4'd8) $display("FAIL full_cnt_realloc: got %0d want 8", outstanding_cnt); else passes++;
    $display("pool_full: tag 3 freed and reallocated one cycle later");
  endtask

  task automatic test_unexpected();
    tick();
    checks++; if (err_unexp !== 1'b0) $display("FAIL unexp_pre: got %b want 0", err_unexp); else passes++;
    mem_resp_val = 1'b1; mem_resp_transid = 6'd9; mem_resp_data = 512'h99;
    tick();
    mem_resp_val = 1'b0;
    checks++; if (rsp_val !== 4'b0000) $display("FAIL unexp_range_rsp: got %b want 0000", rsp_val); else passes++;
    checks++; if (err_unexp !== 1'b1) $display("FAIL unexp_range_err: got %b want 1", err_unexp); else passes++;
    checks++; if (outstanding_cnt !== 4'd8) $display("FAIL unexp_cnt: got %0d want 8", outstanding_cnt); else passes++;
    tick();
    checks++; if (err_unexp !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", err_unexp); else passes++;
    $display("unexpected: transid 9 dropped, err_unexp set");
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_rdy = 1'b1;
    req_val = 4'b1111;
    for (int k = 0; k < 4; k++) tick();
    req_val = '0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b1; mem_resp_transid = 6'd0; mem_resp_data = 512'h55;
    tick();
    mem_resp_transid = 6'd9;
    tick();
    mem_resp_val = 1'b0;
    checks++; if (rsp_data !== 512'h55) $display("FAIL mid_rsp_data: got %h want 55", rsp_data[63:0]); else passes++;
    checks++; if (outstanding_cnt !== 4'd3) $display("FAIL mid_cnt: got %0d want 3", outstanding_cnt); else passes++;
    checks++; if (mem_req_val !== 1'b1) $display("FAIL mid_pending: got %b want 1", mem_req_val); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req_val !== 1'b0) $display("FAIL mid_rst_val: got %b want 0", mem_req_val); else passes++;
    checks++; if (mem_req_transid !== 6'd0) $display("FAIL mid_rst_transid: got %0d want 0", mem_req_transid); else passes++;
    checks++; if (mem_req_addr !== 40'd0) $display("FAIL mid_rst_addr: got %h want 0", mem_req_addr); else passes++;
    checks++; if (rsp_data !== 512'd0) $display("FAIL mid_rst_data: got %h want 0", rsp_data[63:0]); else passes++;
    checks++; if (outstanding_cnt !== 4'd0) $display("FAIL mid_rst_cnt: got %0d want 0", outstanding_cnt); else passes++;
    checks++; if (err_unexp !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", err_unexp); else passes++;
    tick();
    rst = 1'b0;
    mem_resp_val = 1'b1; mem_resp_transid = 6'd1; mem_resp_data = 512'h66;
    tick();
    mem_resp_val = 1'b0;
    checks++; if (rsp_val !== 4'b0000) $display("FAIL stale_rsp_val: got %b want 0000", rsp_val); else passes++;
    checks++; if (err_unexp !== 1'b1) $display("FAIL stale_err: got %b want 1", err_unexp); else passes++;
    checks++; if (outstanding_cnt !== 4'd0) $display("FAIL stale_cnt: got %0d want 0", outstanding_cnt); else passes++;
    $display("reset_mid: async reset cleared state, stale tag 1 flagged");
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef TIGHT_ACC_MEM_SCHED_PRIO_EN
    test_fairness();
`else
    test_prio();
`endif
    test_backpressure();
    test_out_of_order();
    test_pool_full();
    test_unexpected();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tight_acc_mem_sched.md
Name: tight_acc_mem_sched

Overview:
- Memory request scheduler in front of the tight accelerator's memory request and response ports.
- Shares one memory request channel among NUM_REQ accelerator lanes using round-robin arbitration.
- Allocates 6-bit transids from a free pool, keeps an owner table, and routes each L2 response back to the lane that issued it.

Parameters:
- NUM_REQ, 4: number of requesting lanes (2..8).
- MAX_OUTSTANDING, 8: tag pool size; transids 0..MAX_OUTSTANDING-1 (1..64).
- ADDR_W, 40: physical address width; matches the DCP_PADDR_MASK width.
- RESP_W, 512: response data width; matches DCP_NOC_RES_DATA_SIZE.

Ports:
- clk, input, 1: clock; all state on rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- req_val, input, NUM_REQ: per-lane request valid.
- req_rdy, output, NUM_REQ: per-lane accept, one-hot or zero; combinational.
- req_addr, input, NUM_REQ*ADDR_W: per-lane address; lane i at bits [i*ADDR_W +: ADDR_W].
- mem_req_val, output, 1: memory request valid.
- mem_req_rdy, input, 1: network accepts the request.
- mem_req_transid, output, 6: allocated tag.
- mem_req_addr, output, ADDR_W: request address.
- mem_resp_val, input, 1: response valid; always accepted, no backpressure.
- mem_resp_transid, input, 6: response tag.
- mem_resp_data, input, RESP_W: response payload.
- rsp_val, output, NUM_REQ: one-hot response strobe to the owning lane, 1 cycle.
- rsp_data, output, RESP_W: response payload, shared by all lanes.
- outstanding_cnt, output, clog2(MAX_OUTSTANDING+1): number of allocated tags.
- err_unexp, output, 1: sticky flag, set by an unexpected response.

Behaviour:
- Reset values, asserted asynchronously:
  - mem_req_val=0, mem_req_transid=0, mem_req_addr=0.
  - rsp_val=0, rsp_data=0, outstanding_cnt=0, err_unexp=0.
  - Every tag entry is invalid; the round-robin pointer is 0, so lane 0 has highest priority first.
- Issue slot is a single output register with two states:
  - EMPTY: mem_req_val=0.
  - PENDING: mem_req_val=1.
  - PENDING -> EMPTY on mem_req_rdy.
  - EMPTY -> PENDING on grant.
  - PENDING with mem_req_rdy=1 and a grant in the same cycle stays PENDING and loads the new request (back-to-back, 1 request per cycle).
- Grant conditions, all evaluated on pre-edge state:
  - the slot is EMPTY or draining this cycle;
  - at least one free tag exists;
  - at least one req_val is high.
- Arbitration and allocation:
  - Winner is the first lane with req_val=1, scanning from last_grant+1 modulo NUM_REQ.
  - req_rdy[winner]=1 in that cycle.
  - The lowest-index free tag is allocated; the entry records valid=1 and owner=winner.
  - The address and tag are registered into the slot; mem_req_val rises the next cycle.
  - last_grant is set to winner.
- Slot fields stay stable while mem_req_val=1 and mem_req_rdy=0.
- Response to a valid entry (mem_resp_val=1, transid < MAX_OUTSTANDING, entry valid):
  - Next cycle: rsp_val[owner]=1 for exactly 1 cycle and rsp_data=mem_resp_data.
  - The entry is freed at the same edge.
  - Latency is 1 cycle.
- Unexpected response (transid >= MAX_OUTSTANDING or entry invalid):
  - Dropped; rsp_val stays 0.
  - err_unexp=1 until reset.
- Simultaneous free and allocate: a tag freed at edge N is allocatable only from cycle N+1. outstanding_cnt = +1 on alloc, -1 on free, both in the same cycle leave it unchanged.
- Full pool (outstanding_cnt == MAX_OUTSTANDING): all req_rdy=0; the slot, if PENDING, still drains.
- outstanding_cnt counts tags from allocation until response, including a tag still waiting in the slot.
- Reset mid-operation: all tags are discarded. Responses arriving after reset for pre-reset tags count as unexpected (err_unexp=1).
- Requesters must hold req_val and req_addr until req_rdy; a request is never dropped once granted.

Optional Feature:
- Macro: TIGHT_ACC_MEM_SCHED_PRIO_EN.
- Defined: lane 0 has fixed priority; when req_val[0]=1 it wins regardless of the pointer. Other lanes use round-robin among themselves, and a lane-0 win does not update the pointer.
- Undefined: pure round-robin over all lanes as described above.

Test Plan:
- Single request: req_val=0001, addr 0x1000, mem_req_rdy=1 -> next cycle mem_req_val=1, transid=0, addr=0x1000. Then mem_resp_val with transid 0, data 0xAB -> next cycle rsp_val=0001, rsp_data=0xAB, outstanding_cnt back to 0.
- Fairness: all 4 lanes hold req_val=1111, mem_req_rdy=1, no responses -> grants in order lanes 0,1,2,3,0,1,2,3, transids 0..7. Then req_rdy=0000 and outstanding_cnt=8.
- Backpressure: mem_req_rdy=0 for 5 cycles after issue -> mem_req_val, transid and addr stay stable; no further grant. On mem_req_rdy=1 a new grant is issued in the same cycle.
- Out-of-order return: tags 0(lane1), 1(lane2), 2(lane3) outstanding; responses arrive in order 2,0,1 -> rsp_val=1000, then 0010, then 0100. Pool full: a response frees tag 3 while lane 0 requests in the same cycle -> no grant that cycle; grant of tag 3 next cycle.
- Unexpected response: mem_resp_transid=9 with MAX_OUTSTANDING=8, or a response to a freed tag -> rsp_val stays 0, err_unexp=1 and held. Assert rst mid-flight with 3 tags outstanding -> all outputs return to reset values immediately.
- With TIGHT_ACC_MEM_SCHED_PRIO_EN defined: req_val=1111 held for 4 grants -> lane 0 wins every grant; with lane 0 idle the order is 1,2,3.
